// File: rtl/pipe_skid_register.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_skid_register
//  Purpose  : Elastic two-entry pipeline register with valid/ready handshake
//             on both sides and a synchronous flush. A skid entry absorbs one
//             word of downstream back-pressure, so o_ready is a register and
//             never depends combinationally on i_ready.
//  Ports    :
//    i_clk    in   1           clock, rising edge
//    i_rst    in   1           synchronous active-high reset (beats flush)
//    i_flush  in   1           synchronous clear of all stored words
//    i_valid  in   1           upstream word present on i_data
//    o_ready  out  1           block accepts a word this cycle (registered)
//    i_data   in   DATA_WIDTH  upstream payload
//    o_valid  out  1           o_data holds a valid word
//    i_ready  in   1           downstream accepts o_data this cycle
//    o_data   out  DATA_WIDTH  payload from the main register
//  Revision : 1.0  initial release
// ============================================================================
module pipe_skid_register #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data
);

  // State encoding is {main_valid, skid_valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] main_data;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  ready_q;
  logic                  in_xfer;
  logic                  out_xfer;

  assign in_xfer  = i_valid && ready_q;
  assign out_xfer = state[1] && i_ready;

  assign o_valid  = state[1];
  assign o_ready  = ready_q;
  assign o_data   = main_data;

  always_ff @(posedge i_clk) begin
    // Reset and flush reach the same end state; reset simply wins when both
    // are high. An output transfer in this cycle has already been seen by the
    // downstream, so dropping the main word here completes it.
    if (i_rst || i_flush) begin
      state     <= EMPTY;
      main_data <= '0;
      skid_data <= '0;
      ready_q   <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            state     <= BUSY;
            main_data <= i_data;
          end
        end
        BUSY: begin
          if (in_xfer && !out_xfer) begin
            // Downstream stalled: park the new word and close the input.
            state     <= FULL;
            skid_data <= i_data;
            ready_q   <= 1'b0;
          end else if (in_xfer && out_xfer) begin
            main_data <= i_data;
          end else if (out_xfer) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          // ready_q is low here, so no input transfer can occur.
          if (out_xfer) begin
            state     <= BUSY;
            main_data <= skid_data;
            skid_data <= '0;
            ready_q   <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          main_data <= '0;
          skid_data <= '0;
          ready_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_register.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_skid_register
//  Purpose  : Self-checking bench for pipe_skid_register. A queue-based model
//             (capacity two, FIFO order) predicts o_valid, o_ready and o_data
//             after every clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_skid_register;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready_dut;
  logic [DW-1:0] in_data;
  logic          out_valid_dut;
  logic          down_ready;
  logic [DW-1:0] out_data_dut;

  pipe_skid_register #(.DATA_WIDTH(DW)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .i_valid (in_valid),
    .o_ready (out_ready_dut),
    .i_data  (in_data),
    .o_valid (out_valid_dut),
    .i_ready (down_ready),
    .o_data  (out_data_dut)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the words held by the block, oldest first.
  logic [DW-1:0] model_q[$];
  // Set after reset/flush: o_data must read 0 until a word is loaded.
  bit            clr_zero = 1'b1;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Drive one cycle, advance the model across the edge, then compare.
  task automatic cycle(input string tag, input bit r, input bit f,
                       input bit v, input logic [DW-1:0] d, input bit rdy);
    bit do_out;
    bit do_in;
    rst        = r;
    flush      = f;
    in_valid   = v;
    in_data    = d;
    down_ready = rdy;
    do_out = (model_q.size() > 0) && rdy;
    do_in  = v && (model_q.size() < 2);
    @(posedge clk);
    if (r || f) begin
      model_q.delete();
      clr_zero = 1'b1;
    end else begin
      if (do_out) void'(model_q.pop_front());
      if (do_in) begin
        model_q.push_back(d);
        clr_zero = 1'b0;
      end
    end
    #1;
    check({tag, ".valid"}, DW'(out_valid_dut), DW'(model_q.size() > 0));
    check({tag, ".ready"}, DW'(out_ready_dut), DW'(model_q.size() < 2));
    if (model_q.size() > 0)
      check({tag, ".data"}, out_data_dut, model_q[0]);
    else if (clr_zero)
      check({tag, ".data0"}, out_data_dut, '0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; down_ready = 1'b0;

    // Reset then idle.
    cycle("rst", 1, 0, 0, '0, 0);
    cycle("rst", 1, 0, 0, '0, 0);
    cycle("idle", 0, 0, 0, '0, 0);
    check("idle.o_data", out_data_dut, '0);

    // Streaming at full rate.
    cycle("stream", 0, 0, 1, 64'h11, 1);
    cycle("stream", 0, 0, 1, 64'h22, 1);
    cycle("stream", 0, 0, 1, 64'h33, 1);
    cycle("stream", 0, 0, 0, 64'hdead, 1);
    cycle("stream", 0, 0, 0, '0, 1);

    // Back-pressure: A, B fill both entries; C is refused.
    cycle("bp", 0, 0, 1, 64'hA, 0);
    cycle("bp", 0, 0, 1, 64'hB, 0);
    check("bp.full_ready", DW'(out_ready_dut), '0);
    cycle("bp", 0, 0, 1, 64'hC, 0);
    cycle("bp", 0, 0, 1, 64'hC, 0);
    cycle("drain", 0, 0, 1, 64'hC, 1);   // A leaves, C still refused
    cycle("drain", 0, 0, 1, 64'hC, 1);   // B leaves, C accepted
    cycle("drain", 0, 0, 0, '0, 1);      // C leaves
    cycle("drain", 0, 0, 0, '0, 1);

    // Simultaneous in/out in BUSY.
    cycle("sim", 0, 0, 1, 64'h5, 0);
    cycle("sim", 0, 0, 1, 64'h6, 1);
    check("sim.o_data", out_data_dut, 64'h6);
    cycle("sim", 0, 0, 0, '0, 1);

    // Flush in FULL with an input offered.
    cycle("fl", 0, 0, 1, 64'hA, 0);
    cycle("fl", 0, 0, 1, 64'hB, 0);
    cycle("fl", 0, 1, 1, 64'hF, 0);
    check("fl.o_data", out_data_dut, '0);
    cycle("fl", 0, 0, 0, '0, 1);
    cycle("fl", 0, 0, 0, '0, 1);

    // Reset beats flush while BUSY.
    cycle("rp", 0, 0, 1, 64'h7, 0);
    cycle("rp", 1, 1, 0, '0, 0);
    cycle("rp", 0, 0, 1, 64'h9, 0);
    check("rp.o_data", out_data_dut, 64'h9);
    cycle("rp", 0, 0, 0, '0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle("rnd",
            ($urandom_range(0, 199) == 0),
            ($urandom_range(0, 49) == 0),
            bit'($urandom_range(0, 3) != 0),
            {$urandom, $urandom},
            bit'($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
